// File: rtl/regfile_multiport_pkg.sv
// regfile_pkg: shared FSM state type and depth helper for regfile_multiport
package regfile_pkg;
  typedef enum logic {CLEAR, RUN} rf_state_t;
  function automatic int rf_depth(input int r_size);
    return 1 << r_size;
  endfunction
endpackage

// File: rtl/regfile_multiport_if.sv
// regfile_multiport_if: write/read/clear bus; master drives clearIn, writeEnable, wrAddressIn, dataIn, rdAddressIn; slave drives rdDataOut, ready
interface regfile_multiport_if #(parameter int N = 8, parameter int R_SIZE = 3, parameter int NUM_RD = 2);
  logic                     clearIn;
  logic                     writeEnable;
  logic [R_SIZE-1:0]        wrAddressIn;
  logic [N-1:0]             dataIn;
  logic [NUM_RD*R_SIZE-1:0] rdAddressIn;
  logic [NUM_RD*N-1:0]      rdDataOut;
  logic                     ready;
  modport master(output clearIn, writeEnable, wrAddressIn, dataIn, rdAddressIn, input rdDataOut, ready);
  modport slave(input clearIn, writeEnable, wrAddressIn, dataIn, rdAddressIn, output rdDataOut, ready);
endinterface

// File: rtl/regfile_multiport_read_port.sv
// regfile_read_port: one read port (i_run, i_we, i_addr, i_wr_addr, i_wr_data, i_regs -> o_data) with zero/bypass/array mux
module regfile_read_port #(
  parameter int N        = 8,
  parameter int R_SIZE   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int DEPTH    = 8
) (
  input  logic              i_run,
  input  logic              i_we,
  input  logic [R_SIZE-1:0] i_addr,
  input  logic [R_SIZE-1:0] i_wr_addr,
  input  logic [N-1:0]      i_wr_data,
  input  logic [DEPTH*N-1:0] i_regs,
  output logic [N-1:0]      o_data
);
  always_comb
    o_data = (!i_run || (ZERO_REG != 0 && i_addr == '0)) ? '0 :
             (BYPASS != 0 && i_we && i_addr == i_wr_addr) ? i_wr_data :
             i_regs[i_addr*N +: N];
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: multi-read-port register file with clear engine (clk, rst, bus: slave modport of regfile_multiport_if)
module regfile_multiport import regfile_pkg::*; #(
  parameter int N        = 8,
  parameter int R_SIZE   = 3,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic clk,
  input logic rst,
  regfile_multiport_if.slave bus
);
  localparam int DEPTH = rf_depth(R_SIZE);
  rf_state_t         r_state;
  logic [R_SIZE-1:0] r_clr_cnt;
  logic [N-1:0]      r_regs [DEPTH];
  logic [DEPTH*N-1:0] w_regs;
  logic              w_run;
  logic              w_wr;
  assign w_run     = r_state == RUN;
  assign w_wr      = w_run && bus.writeEnable && !(ZERO_REG != 0 && bus.wrAddressIn == '0);
  assign bus.ready = w_run;
  always_ff @(posedge clk)
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
      if (&r_clr_cnt) r_state <= RUN;
    end else if (bus.clearIn) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end
  // Storage has no reset; only the clear engine initialises it.
  always_ff @(posedge clk)
    if (!rst && r_state == CLEAR) r_regs[r_clr_cnt] <= '0;
    else if (!rst && w_wr) r_regs[bus.wrAddressIn] <= bus.dataIn;
  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign w_regs[g*N +: N] = r_regs[g];
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_port #(
      .N(N), .R_SIZE(R_SIZE), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS), .DEPTH(DEPTH)
    ) u_rd (
      .i_run    (w_run),
      .i_we     (bus.writeEnable),
      .i_addr   (bus.rdAddressIn[k*R_SIZE +: R_SIZE]),
      .i_wr_addr(bus.wrAddressIn),
      .i_wr_data(bus.dataIn),
      .i_regs   (w_regs),
      .o_data   (bus.rdDataOut[k*N +: N])
    );
  end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed table-driven checks of three regfile_multiport configurations
module tb_regfile_multiport;
  import regfile_pkg::*;
  logic clk = 0;
  logic rst = 1;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  regfile_multiport_if #(.N(8), .R_SIZE(3), .NUM_RD(2)) b0 ();
  regfile_multiport_if #(.N(8), .R_SIZE(3), .NUM_RD(2)) b1 ();
  regfile_multiport_if #(.N(16), .R_SIZE(4), .NUM_RD(3)) b2 ();
  regfile_multiport #(.N(8), .R_SIZE(3), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) d0 (.clk(clk), .rst(rst), .bus(b0.slave));
  regfile_multiport #(.N(8), .R_SIZE(3), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) d1 (.clk(clk), .rst(rst), .bus(b1.slave));
  regfile_multiport #(.N(16), .R_SIZE(4), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1)) d2 (.clk(clk), .rst(rst), .bus(b2.slave));
  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] di;
    logic [2:0] r0, r1;
    logic [7:0] a0, a1, e0, e1;
  } vec_t;
  vec_t vt [10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] di, input logic [2:0] r0, input logic [2:0] r1);
    b0.writeEnable = we; b0.wrAddressIn = wa; b0.dataIn = di; b0.rdAddressIn = {r1, r0};
    b1.writeEnable = we; b1.wrAddressIn = wa; b1.dataIn = di; b1.rdAddressIn = {r1, r0};
  endtask
  task automatic count_clear(input int expect0, input int expect1, input int expect2, input logic drop_we);
    int c0, c1, c2;
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 20; i++) begin
      if (!b0.ready) c0++;
      if (!b1.ready) c1++;
      if (!b2.ready) c2++;
      if (b0.ready && drop_we) begin
        b0.writeEnable = 0;
        b1.writeEnable = 0;
      end
      step();
    end
    chk("clear_len_d0", c0, expect0);
    chk("clear_len_d1", c1, expect1);
    chk("clear_len_d2", c2, expect2);
  endtask
  initial begin
    vt[0] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[1] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd3, 8'hA5, 8'hA5, 8'h00, 8'h00};
    vt[2] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    vt[3] = '{1'b1, 3'd0, 8'h5A, 3'd0, 3'd3, 8'h00, 8'hA5, 8'h00, 8'hA5};
    vt[4] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 8'h00, 8'h00, 8'h5A, 8'h5A};
    vt[5] = '{1'b1, 3'd5, 8'h3C, 3'd5, 3'd4, 8'h3C, 8'h00, 8'h00, 8'h00};
    vt[6] = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd5, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
    vt[7] = '{1'b1, 3'd5, 8'hC3, 3'd5, 3'd3, 8'hC3, 8'hA5, 8'h3C, 8'hA5};
    vt[8] = '{1'b1, 3'd7, 8'hFF, 3'd5, 3'd7, 8'hC3, 8'hFF, 8'hC3, 8'h00};
    vt[9] = '{1'b0, 3'd0, 8'h00, 3'd7, 3'd1, 8'hFF, 8'h00, 8'hFF, 8'h00};
    for (int i = 0; i < 8; i++) begin
      d0.r_regs[i] = 8'hFF;
      d1.r_regs[i] = 8'hFF;
    end
    for (int i = 0; i < 16; i++) d2.r_regs[i] = 16'hFFFF;
    drive(0, 0, 0, 0, 0);
    b0.clearIn = 0; b1.clearIn = 0; b2.clearIn = 0;
    b2.writeEnable = 0; b2.wrAddressIn = 0; b2.dataIn = 0; b2.rdAddressIn = {4'd1, 4'd2, 4'd3};
    drive(0, 0, 0, 3, 5);
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("reset_ready_d0", b0.ready, 0);
    chk("reset_rd_d0", b0.rdDataOut, 0);
    chk("reset_rd_d1", b1.rdDataOut, 0);
    chk("reset_rd_d2", b2.rdDataOut, 0);
    count_clear(8, 8, 16, 0);
    chk("ready_after_clear", b0.ready, 1);
    for (int a = 0; a < 8; a++) begin
      drive(0, 0, 0, 3'(a), 3'(7 - a));
      #1;
      chk("cleared_d0", b0.rdDataOut, 0);
      chk("cleared_d1", b1.rdDataOut, 0);
    end
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].we, vt[i].wa, vt[i].di, vt[i].r0, vt[i].r1);
      #1;
      chk($sformatf("vec%0d_d0_p0", i), b0.rdDataOut[7:0], vt[i].a0);
      chk($sformatf("vec%0d_d0_p1", i), b0.rdDataOut[15:8], vt[i].a1);
      chk($sformatf("vec%0d_d1_p0", i), b1.rdDataOut[7:0], vt[i].e0);
      chk($sformatf("vec%0d_d1_p1", i), b1.rdDataOut[15:8], vt[i].e1);
      step();
    end
    drive(0, 0, 0, 0, 0);
    b2.writeEnable = 1; b2.wrAddressIn = 4'd15; b2.dataIn = 16'hBEEF;
    b2.rdAddressIn = {4'd15, 4'd15, 4'd15};
    #1;
    chk("wide_bypass", b2.rdDataOut, {3{16'hBEEF}});
    step();
    b2.writeEnable = 0;
    #1;
    chk("wide_stored", b2.rdDataOut, {3{16'hBEEF}});
    b2.rdAddressIn = {4'd15, 4'd14, 4'd0};
    #1;
    chk("wide_mixed", b2.rdDataOut, {16'hBEEF, 16'h0000, 16'h0000});
    for (int a = 1; a < 8; a++) begin
      drive(1, 3'(a), 8'(a * 8'h11), 0, 0);
      step();
    end
    drive(0, 0, 0, 7, 2);
    #1;
    chk("fill_d0", b0.rdDataOut, {8'h22, 8'h77});
    drive(1, 2, 8'h99, 2, 1);
    b0.clearIn = 1; b1.clearIn = 1;
    step();
    b0.clearIn = 0; b1.clearIn = 0;
    drive(1, 1, 8'hEE, 2, 1);
    #1;
    chk("clearing_rd_d0", b0.rdDataOut, 0);
    chk("clearing_rd_d1", b1.rdDataOut, 0);
    count_clear(8, 8, 0, 1);
    for (int a = 0; a < 8; a++) begin
      drive(0, 0, 0, 3'(a), 3'(a));
      #1;
      chk("reclear_d0", b0.rdDataOut, 0);
      chk("reclear_d1", b1.rdDataOut, 0);
    end
    b0.clearIn = 1; b1.clearIn = 1;
    step();
    b0.clearIn = 0; b1.clearIn = 0;
    for (int i = 0; i < 4; i++) step();
    chk("midclear_ready", b0.ready, 0);
    rst = 1;
    step();
    rst = 0;
    count_clear(8, 8, 16, 0);
    b2.rdAddressIn = {4'd15, 4'd15, 4'd15};
    #1;
    chk("wide_after_rst", b2.rdDataOut, 0);
    chk("final_ready", {b0.ready, b1.ready, b2.ready}, 3'b111);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
